// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO fed by a UART receiver's rxDataAvailable/rxData pair.
// Optional buffered-newline counter enabled by defining UART_RX_FIFO_LINE_COUNT_EN.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxDataAvailable,
  input  logic [7:0]             rxData,
  input  logic                   readEnable,
  input  logic                   clearOverflow,
  output logic [7:0]             readData,
  output logic                   dataAvailable,
  output logic                   full,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic [15:0]            lineCount,
  output logic                   lineAvailable
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);

  // Producer side: one byte per rising edge of rxDataAvailable, no backpressure.
  // Consumer side: readData is valid while dataAvailable is high; readEnable
  // pops the head on the clock edge and is ignored while empty.
  logic             rx_prev;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       mem [DEPTH];

  logic push;
  logic pop;
  logic accept;
  logic drop;
  logic is_full;
  logic is_empty;

  always_comb begin
    is_full  = (count == COUNT_FULL);
    is_empty = (count == '0);
    push     = rxDataAvailable & ~rx_prev;
    pop      = readEnable & ~is_empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    accept   = push & (~is_full | pop);
    drop     = push & is_full & ~pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      rx_prev <= rxDataAvailable;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !pop)      count <= count + COUNT_WIDTH'(1);
      else if (pop && !accept) count <= count - COUNT_WIDTH'(1);
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr] <= rxData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overflow <= 1'b0;
    else if (clearOverflow) overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
  end

  assign readData      = mem[rd_ptr];
  assign dataAvailable = ~is_empty;
  assign full          = is_full;

`ifdef UART_RX_FIFO_LINE_COUNT_EN
  logic push_nl;
  logic pop_nl;

  always_comb begin
    push_nl = accept & (rxData == 8'h0A);
    pop_nl  = pop & (mem[rd_ptr] == 8'h0A);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lineCount <= '0;
    end else if (push_nl && !pop_nl) begin
      lineCount <= lineCount + 16'd1;
    end else if (pop_nl && !push_nl) begin
      lineCount <= lineCount - 16'd1;
    end
  end

  assign lineAvailable = (lineCount != '0);
`else
  assign lineCount     = '0;
  assign lineAvailable = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          rxDataAvailable;
  logic [7:0]    rxData;
  logic          readEnable;
  logic          clearOverflow;
  logic [7:0]    readData;
  logic          dataAvailable;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   lineCount;
  logic          lineAvailable;

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];
  logic       model_prev;
  logic       model_ovf;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rxDataAvailable(rxDataAvailable), .rxData(rxData),
    .readEnable(readEnable), .clearOverflow(clearOverflow),
    .readData(readData), .dataAvailable(dataAvailable), .full(full),
    .count(count), .overflow(overflow),
    .lineCount(lineCount), .lineAvailable(lineAvailable)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pop then push on a queue, rising edge detected on the flag
  task automatic model_step(input logic av, input logic [7:0] d, input logic re,
                            input logic clr);
    logic psh, pp, setf;
    psh  = av && !model_prev;
    pp   = re && (exp_q.size() != 0);
    setf = psh && (exp_q.size() == DEPTH) && !pp;
    if (pp) void'(exp_q.pop_front());
    if (psh && exp_q.size() < DEPTH) exp_q.push_back(d);
    if (clr) model_ovf = 1'b0;
    else if (setf) model_ovf = 1'b1;
    model_prev = av;
  endtask

  function automatic int model_lines();
    int n;
    n = 0;
`ifdef UART_RX_FIFO_LINE_COUNT_EN
    foreach (exp_q[i]) if (exp_q[i] == 8'h0A) n++;
`endif
    return n;
  endfunction

  function automatic int model_head();
    return (exp_q.size() != 0) ? int'(exp_q[0]) : 0;
  endfunction

  // driver: apply inputs for one clock, outputs sampled 1 ns after the edge
  task automatic cycle(input logic av, input logic [7:0] d, input logic re,
                       input logic clr);
    rxDataAvailable = av;
    rxData          = d;
    readEnable      = re;
    clearOverflow   = clr;
    model_step(av, d, re, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_prev = 1'b0;
    model_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxDataAvailable = 1'b0; rxData = 8'h00; readEnable = 1'b0; clearOverflow = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (dataAvailable !== 1'b0) begin miscompares++; $display("FAIL reset_avail: got %b want 0", dataAvailable); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vectors++; if (lineAvailable !== 1'b0) begin miscompares++; $display("FAIL reset_lineavail: got %b want 0", lineAvailable); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_hello();
    logic [7:0] msg [5];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, msg[i], 1'b0, 1'b0);
      idle(9);
    end
    vectors++; if (count !== CW'(5)) begin miscompares++; $display("FAIL hello_count: got %0d want 5", count); end
    vectors++; if (readData !== 8'h48) begin miscompares++; $display("FAIL hello_head: got %h want 48", readData); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (readData !== msg[i]) begin miscompares++; $display("FAIL hello_pop%0d: got %h want %h", i, readData, msg[i]); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vectors++; if (dataAvailable !== 1'b0) begin miscompares++; $display("FAIL hello_empty: got %b want 0", dataAvailable); end
  endtask

  task automatic test_level_hold();
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL level_count: got %0d want 1", count); end
    vectors++; if (readData !== 8'h41) begin miscompares++; $display("FAIL level_data: got %h want 41", readData); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL level_drain: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    vectors++; if (count !== CW'(16)) begin miscompares++; $display("FAIL ovf_count: got %0d want 16", count); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (readData !== 8'(i)) begin miscompares++; $display("FAIL ovf_pop%0d: got %h want %h", i, readData, 8'(i)); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] old_head;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    old_head = exp_q[0];
    vectors++; if (readData !== old_head) begin miscompares++; $display("FAIL ppf_oldhead: got %h want %h", readData, old_head); end
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    vectors++; if (count !== CW'(16)) begin miscompares++; $display("FAIL ppf_count: got %0d want 16", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ppf_ovf: got %b want 0", overflow); end
    vectors++; if (readData !== 8'(model_head())) begin miscompares++; $display("FAIL ppf_newhead: got %h want %h", readData, 8'(model_head())); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      vectors++; if (readData !== 8'(model_head())) begin miscompares++; $display("FAIL ppf_pop%0d: got %h want %h", i, readData, 8'(model_head())); end
      if (i == 15) begin
        vectors++; if (readData !== 8'hA5) begin miscompares++; $display("FAIL ppf_tail: got %h want a5", readData); end
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    vectors++; if (dataAvailable !== 1'b0) begin miscompares++; $display("FAIL empty_pop_avail: got %b want 0", dataAvailable); end
    // pop and push together on an empty FIFO: only the push takes effect
    cycle(1'b1, 8'h5C, 1'b1, 1'b0);
    vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL empty_pp_count: got %0d want 1", count); end
    vectors++; if (readData !== 8'h5C) begin miscompares++; $display("FAIL empty_pp_data: got %h want 5c", readData); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_line_count();
    logic [7:0] msg [6];
    int want;
    msg = '{8'h61, 8'h62, 8'h0A, 8'h63, 8'h64, 8'h0A};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, msg[i], 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
`ifdef UART_RX_FIFO_LINE_COUNT_EN
    want = 2;
`else
    want = 0;
`endif
    vectors++; if (lineCount !== 16'(want)) begin miscompares++; $display("FAIL line_count2: got %0d want %0d", lineCount, want); end
    vectors++; if (lineAvailable !== (want != 0)) begin miscompares++; $display("FAIL line_avail: got %b want %b", lineAvailable, want != 0); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    want = (want != 0) ? 1 : 0;
    vectors++; if (lineCount !== 16'(want)) begin miscompares++; $display("FAIL line_count1: got %0d want %0d", lineCount, want); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++; if (lineCount !== 16'd0) begin miscompares++; $display("FAIL line_count0: got %0d want 0", lineCount); end
    vectors++; if (lineAvailable !== 1'b0) begin miscompares++; $display("FAIL line_avail0: got %b want 0", lineAvailable); end
  endtask

  task automatic test_random();
    logic       av, re, clr;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      av  = ($urandom_range(0, 99) < 45);
      re  = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 15 : 55));
      clr = ($urandom_range(0, 99) < 4);
      d   = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      cycle(av, d, re, clr);
      vectors++; if (count !== CW'(exp_q.size())) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, exp_q.size()); end
      vectors++; if (full !== (exp_q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_full@%0d: got %b want %b", i, full, exp_q.size() == DEPTH); end
      vectors++; if (overflow !== model_ovf) begin miscompares++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, model_ovf); end
      vectors++; if (lineCount !== 16'(model_lines())) begin miscompares++; $display("FAIL rnd_lines@%0d: got %0d want %0d", i, lineCount, model_lines()); end
      if (exp_q.size() != 0) begin
        vectors++; if (readData !== exp_q[0]) begin miscompares++; $display("FAIL rnd_head@%0d: got %h want %h", i, readData, exp_q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(1);
    while (exp_q.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, (i == 2) ? 8'h0A : 8'(8'h30 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    vectors++; if (count !== CW'(7)) begin miscompares++; $display("FAIL rstmid_pre: got %0d want 7", count); end
    rst = 1'b1;
    rxDataAvailable = 1'b1; rxData = 8'h33;
    model_reset();
    @(posedge clk);
    #1;
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", count); end
    vectors++; if (dataAvailable !== 1'b0) begin miscompares++; $display("FAIL rstmid_avail: got %b want 0", dataAvailable); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    vectors++; if (lineCount !== 16'd0) begin miscompares++; $display("FAIL rstmid_lines: got %0d want 0", lineCount); end
    rst = 1'b0;
    // flag already high when reset drops counts as a fresh edge
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL rstmid_edge: got %0d want 1", count); end
    vectors++; if (readData !== 8'h33) begin miscompares++; $display("FAIL rstmid_data: got %h want 33", readData); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_hello();
    test_level_hold();
    test_overflow();
    test_push_pop_full();
    test_line_count();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte-buffering stage directly downstream of the UART receiver in the snake/UART test environment. Captures each byte flagged by the receiver's `rxDataAvailable`/`rxData` pair into a show-ahead FIFO, so a testbench sequence or consumer can pop received characters at its own pace without losing bursts at high baud rates. It reports occupancy and a sticky overflow flag and, optionally, counts complete newline-terminated lines held in the buffer.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `COUNT_WIDTH`, `$clog2(DEPTH)+1`: width of the `count` output.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rxDataAvailable`  input  1  byte-valid flag from the UART receiver, pulse or level.
- `rxData`  input  8  received byte; sampled in the same cycle as the `rxDataAvailable` rising edge.
- `readEnable`  input  1  pop request for the head entry.
- `clearOverflow`  input  1  clears `overflow`.
- `readData`  output  8  head byte; valid while `dataAvailable` is high.
- `dataAvailable`  output  1  FIFO non-empty.
- `full`  output  1  `count == DEPTH`.
- `count`  output  `COUNT_WIDTH`  entries held.
- `overflow`  output  1  sticky: a byte was dropped because the FIFO was full.
- `lineCount`  output  16  number of buffered `8'h0A` bytes; used only with `UART_RX_FIFO_LINE_COUNT_EN`.
- `lineAvailable`  output  1  `lineCount != 0`.

## Operation
- Edge detect:
  - register `rxPrev <= rxDataAvailable`.
  - `push = rxDataAvailable & ~rxPrev`, so a level held high for N cycles yields exactly one push.
- Storage: `DEPTH`×8 array with write pointer and read pointer, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`. `count` is a separate register.
- Pop: `pop = readEnable & (count != 0)`. `readEnable` on an empty FIFO is ignored; no pointer movement and no error.
- Push, not full: write `rxData` at the write pointer and advance it.
- Push, full, no pop: drop the byte, set `overflow`; pointers and contents are unchanged.
- Push and pop in the same cycle, full: both are performed; `count` stays at `DEPTH` and `overflow` is not set.
- Push and pop in the same cycle, empty: the pop is ignored and the push is performed.
- Push and pop in the same cycle, otherwise: both are performed and `count` is unchanged.
- `count` update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- `readData = mem[readPtr]`, show-ahead. After a pop it shows the next entry from the following cycle.
- Overflow flag:
  - `clearOverflow` clears `overflow` and has priority over a set.
  - A set and clear in the same cycle results in 0.
  - A set on the following cycle is still honoured.

## Timing
- Reset values: `rxPrev`=0, both pointers=0, `count`=0, `overflow`=0, `lineCount`=0. Memory contents are not reset.
- Outputs after reset: `dataAvailable`=0, `full`=0, `lineAvailable`=0; `readData` is don't-care while empty.
- Write latency: with the `rxDataAvailable` rising edge in cycle T, the byte is written at the end of T. `dataAvailable`, `count` and `readData` reflect it from cycle T+1.
- Pop latency: with `readEnable` high in cycle T, the head advances at the end of T. The new head and count are visible in T+1.
- All outputs come from registers or from memory indexed by a register; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation: the FIFO immediately reads empty and any in-flight push is lost. After deassertion, an `rxDataAvailable` already high counts as a rising edge, because `rxPrev` is 0.

## Configuration
- Macro: `UART_RX_FIFO_LINE_COUNT_EN`.
- Defined:
  - `lineCount` +1 when an accepted push carries `8'h0A`.
  - `lineCount` −1 when a pop removes `8'h0A`.
  - Unchanged when both occur in the same cycle.
  - A dropped (overflowed) `8'h0A` is not counted.
  - Lets the bench wait for `lineAvailable` and then pop a whole line.
- Undefined: `lineCount` is tied to 0, `lineAvailable` is tied to 0, and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Reset, then push "Hello" as 1-cycle pulses 10 cycles apart. Required: `count`=5 and `readData`="H"; five pops return "H","e","l","l","o"; `dataAvailable`=0 after the final pop.
- Hold `rxDataAvailable` high for 20 cycles with `rxData`=8'h41. Required: exactly one entry, `count`=1.
- With `DEPTH`=16, push 17 bytes 8'h00–8'h10 with no pops. Required: `full`=1, `overflow`=1, pops return 8'h00–8'h0F. Then pulse `clearOverflow`. Required: `overflow`=0.
- Fill to 16, then push and pop in the same cycle. Required: `count` stays 16, `overflow`=0, the popped byte is the old head and the new byte is the tail. On an empty FIFO, `readEnable` alone leaves `count`=0.
- With the macro defined, push "ab\ncd\n". Required: `lineCount`=2, `lineAvailable`=1; after popping 3 bytes `lineCount`=1; after popping all, `lineCount`=0.
- Assert `rst` with 7 entries buffered. Required: next cycle `count`=0, `dataAvailable`=0, `overflow`=0, `lineCount`=0.
